// File: rtl/shifter_pipe_if.sv
// shifter_pipe_if
//   Handshake bundle between the operand-fetch side, the pipelined barrel
//   shifter and the ALU result mux.
//   Parameter:
//     WIDTH      operand width (power of two, >= 4)
//   Signals:
//     in_valid   operation present            (master -> slave)
//     in_ready   shifter can accept           (slave  -> master)
//     in_data    operand, WIDTH bits          (master -> slave)
//     in_amt     shift amount, $clog2(WIDTH)  (master -> slave)
//     in_op      00 SRL, 01 SLL, 10 SRA, 11 ROR (master -> slave)
//     out_valid  result present               (slave  -> master)
//     out_ready  downstream accepts result    (master -> slave)
//     out_data   shifted result, WIDTH bits   (slave  -> master)
//   The master modport is the environment around the shifter; the slave
//   modport is the shifter itself.
interface shifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shifter_pipe.sv
// shifter_pipe
//   Pipelined barrel shifter: SRL, SLL, SRA and optional ROR on a WIDTH-bit
//   operand. There are $clog2(WIDTH) register stages; stage k shifts by 2^k
//   when amount bit k is set. Stages form an elastic chain with a
//   combinational ready path, so one operation per cycle is sustained and
//   back-pressure stalls the chain without loss or duplication.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears every stage)
//     bus    shifter_pipe_if.slave (in_* request side, out_* result side)
//   Configuration macro:
//     SHIFTER_PIPE_ROTATE_EN  defined: op 11 rotates right.
//                             undefined: no rotate logic; op 11 acts as SRL.
module shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  shifter_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  // Per-stage registers
  logic [SHW-1:0]            valid_q, valid_d;
  logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0][1:0]       op_q,    op_d;
  logic [SHW-1:0][SHW-1:0]   amt_q,   amt_d;
  logic [SHW-1:0]            sign_q,  sign_d;

  // What each stage would load if it advances
  logic [SHW-1:0]            src_valid;
  logic [SHW-1:0][WIDTH-1:0] src_data;
  logic [SHW-1:0][1:0]       src_op;
  logic [SHW-1:0][SHW-1:0]   src_amt;
  logic [SHW-1:0]            src_sign;

  logic [SHW-1:0]            load;

  // Shift by a fixed power of two. SRA fills with the sign captured at
  // entry rather than the current MSB.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               sh
  );
    logic [WIDTH-1:0] hi_mask;
    hi_mask     = ~({WIDTH{1'b1}} >> sh);
    stage_shift = d >> sh;
    case (op)
      2'b01:   stage_shift = d << sh;
      2'b10:   stage_shift = (d >> sh) | (sign ? hi_mask : '0);
`ifdef SHIFTER_PIPE_ROTATE_EN
      2'b11:   stage_shift = (d >> sh) | (d << (WIDTH - sh));
`endif
      default: stage_shift = d >> sh;
    endcase
  endfunction

  // Stage 0 is fed from the bus, every later stage from its predecessor.
  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_valid[gi] = bus.in_valid;
        assign src_data[gi]  = bus.in_data;
        assign src_op[gi]    = bus.in_op;
        assign src_amt[gi]   = bus.in_amt;
        assign src_sign[gi]  = bus.in_data[WIDTH-1];
      end else begin : g_body
        assign src_valid[gi] = valid_q[gi-1];
        assign src_data[gi]  = data_q[gi-1];
        assign src_op[gi]    = op_q[gi-1];
        assign src_amt[gi]   = amt_q[gi-1];
        assign src_sign[gi]  = sign_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    logic nxt_load;
    load    = '0;
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    amt_d   = amt_q;
    sign_d  = sign_q;

    // Ready chain from the output back to the input: a stage may load when
    // it is empty or its contents move on this cycle. (!v || (v && x))
    // reduces to (!v || x).
    nxt_load = bus.out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      load[k]  = !valid_q[k] || nxt_load;
      nxt_load = load[k];
    end

    for (int k = 0; k < SHW; k++) begin
      if (load[k]) begin
        valid_d[k] = src_valid[k];
        op_d[k]    = src_op[k];
        amt_d[k]   = src_amt[k];
        sign_d[k]  = src_sign[k];
        data_d[k]  = src_amt[k][k]
                     ? stage_shift(src_data[k], src_op[k], src_sign[k], 1 << k)
                     : src_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      sign_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];

  // The last stage's control fields have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{op_q[SHW-1], amt_q[SHW-1], sign_q[SHW-1]};
endmodule
